// File: rtl/cdb_arbiter.sv
// Multi-port common data bus: per-FU result FIFOs drained by a round-robin arbiter
// onto NUM_CDB registered broadcast ports, with flush and backpressure.
module cdb_arbiter #(
    parameter int unsigned NUM_FU     = 4,
    parameter int unsigned NUM_CDB    = 2,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned TAG_W      = 6,
    parameter int unsigned XLEN       = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NUM_FU-1:0]         fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]   fu_tag,
    input  logic [NUM_FU-1:0]         fu_is_zeroreg,
    input  logic [NUM_FU*XLEN-1:0]    fu_value,
    input  logic [NUM_FU*XLEN-1:0]    fu_npc,
    input  logic [NUM_FU-1:0]         fu_take_branch,
    output logic [NUM_FU-1:0]         fu_ready,
    output logic [NUM_CDB-1:0]        cdb_valid,
    output logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    output logic [NUM_CDB-1:0]        cdb_tag_valid,
    output logic [NUM_CDB*XLEN-1:0]   cdb_value,
    output logic [NUM_CDB*XLEN-1:0]   cdb_npc,
    output logic [NUM_CDB-1:0]        cdb_take_branch
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned FU_W  = $clog2(NUM_FU);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             is_zeroreg;
        logic [XLEN-1:0]  value;
        logic [XLEN-1:0]  npc;
        logic             take_branch;
    } entry_t;

    entry_t           mem [NUM_FU][FIFO_DEPTH];
    entry_t           in_entry [NUM_FU];
    entry_t           port_entry [NUM_CDB];
    logic [PTR_W-1:0] head_q [NUM_FU];
    logic [PTR_W-1:0] tail_q [NUM_FU];
    logic [CNT_W-1:0] count_q [NUM_FU];
    logic [FU_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NUM_FU-1:0]  push, pop;
    logic [NUM_CDB-1:0] grant_valid;
    logic [FU_W-1:0]    grant_idx [NUM_CDB];

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            in_entry[i].tag         = fu_tag[i*TAG_W +: TAG_W];
            in_entry[i].is_zeroreg  = fu_is_zeroreg[i];
            in_entry[i].value       = fu_value[i*XLEN +: XLEN];
            in_entry[i].npc         = fu_npc[i*XLEN +: XLEN];
            in_entry[i].take_branch = fu_take_branch[i];
            // Ready looks only at the registered count, never at this cycle's pop.
            fu_ready[i] = !reset && (count_q[i] < CNT_W'(FIFO_DEPTH));
            push[i]     = fu_valid[i] && fu_ready[i];
        end
    end

    // Round-robin scan from rr_ptr; the k-th non-empty FIFO found drives port k.
    always_comb begin
        int unsigned n;
        int unsigned idx;
        n           = 0;
        idx         = 0;
        grant_valid = '0;
        pop         = '0;
        rr_ptr_d    = rr_ptr_q;
        for (int k = 0; k < NUM_CDB; k++) begin
            grant_idx[k] = '0;
        end
        for (int j = 0; j < NUM_FU; j++) begin
            idx = int'(rr_ptr_q) + j;
            if (idx >= NUM_FU) begin
                idx = idx - NUM_FU;
            end
            if (count_q[idx] != '0 && n < NUM_CDB) begin
                grant_valid[n] = 1'b1;
                grant_idx[n]   = FU_W'(idx);
                pop[idx]       = 1'b1;
                rr_ptr_d       = (idx == NUM_FU - 1) ? '0 : FU_W'(idx + 1);
                n              = n + 1;
            end
        end
        for (int k = 0; k < NUM_CDB; k++) begin
            port_entry[k] = mem[grant_idx[k]][head_q[grant_idx[k]]];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                count_q[i] <= '0;
            end
        end else if (flush) begin
            rr_ptr_q <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                count_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < NUM_FU; i++) begin
                if (push[i]) begin
                    tail_q[i] <= tail_q[i] + 1'b1;
                end
                if (pop[i]) begin
                    head_q[i] <= head_q[i] + 1'b1;
                end
                unique case ({push[i], pop[i]})
                    2'b10:   count_q[i] <= count_q[i] + 1'b1;
                    2'b01:   count_q[i] <= count_q[i] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Storage needs no reset: an entry is only read once count says it was written.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push[i] && !flush) begin
                mem[i][tail_q[i]] <= in_entry[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cdb_valid       <= '0;
            cdb_tag         <= '0;
            cdb_tag_valid   <= '0;
            cdb_value       <= '0;
            cdb_npc         <= '0;
            cdb_take_branch <= '0;
        end else if (flush) begin
            cdb_valid <= '0;
        end else begin
            for (int k = 0; k < NUM_CDB; k++) begin
                cdb_valid[k] <= grant_valid[k];
                if (grant_valid[k]) begin
                    cdb_tag[k*TAG_W +: TAG_W]  <= port_entry[k].tag;
                    cdb_tag_valid[k]           <= !port_entry[k].is_zeroreg;
                    cdb_value[k*XLEN +: XLEN]  <= port_entry[k].value;
                    cdb_npc[k*XLEN +: XLEN]    <= port_entry[k].npc;
                    cdb_take_branch[k]         <= port_entry[k].take_branch;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts are queued as stimulus is
// applied and compared against the CDB ports after each clock edge.
module tb_cdb_arbiter;

    logic        clock;
    logic        reset;
    logic        flush;
    logic [3:0]  fu_valid;
    logic [23:0] fu_tag;
    logic [3:0]  fu_is_zeroreg;
    logic [127:0] fu_value;
    logic [127:0] fu_npc;
    logic [3:0]  fu_take_branch;
    logic [3:0]  fu_ready;
    logic [1:0]  cdb_valid;
    logic [11:0] cdb_tag;
    logic [1:0]  cdb_tag_valid;
    logic [63:0] cdb_value;
    logic [63:0] cdb_npc;
    logic [1:0]  cdb_take_branch;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]        valid;
        logic [1:0][5:0]   tag;
        logic [1:0]        tv;
        logic [1:0][31:0]  value;
        logic [1:0][31:0]  npc;
        logic [1:0]        br;
    } exp_t;

    exp_t exp_q[$];

    cdb_arbiter #(
        .NUM_FU(4), .NUM_CDB(2), .FIFO_DEPTH(2), .TAG_W(6), .XLEN(32)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_is_zeroreg(fu_is_zeroreg),
        .fu_value(fu_value), .fu_npc(fu_npc), .fu_take_branch(fu_take_branch),
        .fu_ready(fu_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_tag_valid(cdb_tag_valid),
        .cdb_value(cdb_value), .cdb_npc(cdb_npc), .cdb_take_branch(cdb_take_branch)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic clear_inputs();
        fu_valid = '0; fu_tag = '0; fu_is_zeroreg = '0;
        fu_value = '0; fu_npc = '0; fu_take_branch = '0;
    endtask

    task automatic set_fu_full(input int i, input logic [5:0] t, input logic zr,
                               input logic [31:0] v, input logic [31:0] n, input logic b);
        fu_valid[i]          = 1'b1;
        fu_tag[i*6 +: 6]     = t;
        fu_is_zeroreg[i]     = zr;
        fu_value[i*32 +: 32] = v;
        fu_npc[i*32 +: 32]   = n;
        fu_take_branch[i]    = b;
    endtask

    // Generic entry: value/npc/branch derived from the tag.
    task automatic set_fu(input int i, input logic [5:0] t);
        set_fu_full(i, t, 1'b0, 32'h1000 + 32'(t), 32'h2000 + 32'(t), t[0]);
    endtask

    function automatic exp_t mk(input logic [1:0] v, input logic [5:0] t0, input logic [5:0] t1,
                                input logic [1:0] tv, input logic [31:0] v0, input logic [31:0] v1,
                                input logic [31:0] n0, input logic [31:0] n1, input logic [1:0] br);
        exp_t e;
        e.valid = v; e.tag[0] = t0; e.tag[1] = t1; e.tv = tv;
        e.value[0] = v0; e.value[1] = v1; e.npc[0] = n0; e.npc[1] = n1; e.br = br;
        return e;
    endfunction

    function automatic exp_t pair(input logic [1:0] v, input logic [5:0] t0, input logic [5:0] t1);
        return mk(v, t0, t1, 2'b11, 32'h1000 + 32'(t0), 32'h1000 + 32'(t1),
                  32'h2000 + 32'(t0), 32'h2000 + 32'(t1), {t1[0], t0[0]});
    endfunction

    task automatic compare_out(input string name, input exp_t e);
        check({name, ".valid"}, 64'(cdb_valid), 64'(e.valid));
        for (int k = 0; k < 2; k++) begin
            if (e.valid[k]) begin
                check($sformatf("%s.p%0d.tag", name, k), 64'(cdb_tag[k*6 +: 6]), 64'(e.tag[k]));
                check($sformatf("%s.p%0d.tv", name, k), 64'(cdb_tag_valid[k]), 64'(e.tv[k]));
                check($sformatf("%s.p%0d.value", name, k), 64'(cdb_value[k*32 +: 32]),
                      64'(e.value[k]));
                check($sformatf("%s.p%0d.npc", name, k), 64'(cdb_npc[k*32 +: 32]), 64'(e.npc[k]));
                check($sformatf("%s.p%0d.br", name, k), 64'(cdb_take_branch[k]), 64'(e.br[k]));
            end
        end
    endtask

    // One clock: queue what the ports must show after this edge, then compare.
    task automatic cyc(input string name, input exp_t e);
        exp_t got;
        check({name, ".protocol"}, 64'(fu_valid & ~fu_ready), 64'd0);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        got = exp_q.pop_front();
        compare_out(name, got);
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".valid"}, 64'(cdb_valid), 64'd0);
        check({name, ".tag"}, 64'(cdb_tag), 64'd0);
        check({name, ".tv"}, 64'(cdb_tag_valid), 64'd0);
        check({name, ".value"}, cdb_value, 64'd0);
        check({name, ".npc"}, cdb_npc, 64'd0);
        check({name, ".br"}, 64'(cdb_take_branch), 64'd0);
        check({name, ".ready"}, 64'(fu_ready), 64'd0);
    endtask

    exp_t none;

    initial begin
        none  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        flush = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        #1;
        check("ready_after_reset", 64'(fu_ready), 64'hF);

        // All four FUs at once from rr_ptr=0: tags 1,2 then 3,4.
        for (int i = 0; i < 4; i++) set_fu(i, 6'(i + 1));
        cyc("all4.enq", none);
        clear_inputs();
        cyc("all4.c1", pair(2'b11, 6'd1, 6'd2));
        cyc("all4.c2", pair(2'b11, 6'd3, 6'd4));
        cyc("all4.idle", none);

        // Single result, one-cycle latency.
        set_fu_full(0, 6'd5, 1'b0, 32'h1234, 32'h104, 1'b0);
        cyc("single.enq", none);
        clear_inputs();
        cyc("single.out", mk(2'b01, 6'd5, 0, 2'b01, 32'h1234, 0, 32'h104, 0, 2'b00));
        cyc("single.idle", none);

        // Fairness with FU1..3 streaming; rr_ptr starts at 1.
        set_fu(1, 6'h11); set_fu(2, 6'h21); set_fu(3, 6'h31);
        cyc("rr.e1", none);
        set_fu(1, 6'h12); set_fu(2, 6'h22); set_fu(3, 6'h32);
        cyc("rr.e2", pair(2'b11, 6'h11, 6'h21));
        check("rr.ready_e3", 64'(fu_ready), 64'b0111);
        clear_inputs();
        set_fu(1, 6'h13); set_fu(2, 6'h23);
        cyc("rr.e3", pair(2'b11, 6'h31, 6'h12));
        check("rr.ready_e4", 64'(fu_ready), 64'b1011);
        clear_inputs();
        cyc("rr.e4", pair(2'b11, 6'h22, 6'h32));
        cyc("rr.e5", pair(2'b11, 6'h13, 6'h23));
        cyc("rr.e6", none);

        // Zero-register write still carries npc and branch outcome.
        set_fu_full(1, 6'h3F, 1'b1, 32'hDEAD, 32'h40, 1'b1);
        cyc("zr.enq", none);
        clear_inputs();
        cyc("zr.out", mk(2'b01, 6'h3F, 0, 2'b00, 32'hDEAD, 0, 32'h40, 0, 2'b01));
        cyc("zr.idle", none);

        // Load all FIFOs, then flush: nothing buffered may ever appear.
        for (int i = 0; i < 4; i++) set_fu(i, 6'(8'h28 + i));
        cyc("fl.f1", none);
        for (int i = 0; i < 4; i++) set_fu(i, 6'(8'h2C + i));
        cyc("fl.f2", pair(2'b11, 6'h2A, 6'h2B));
        check("fl.ready_f3", 64'(fu_ready), 64'b1100);
        clear_inputs();
        flush = 1'b1;
        set_fu(2, 6'h01); set_fu(3, 6'h02);
        cyc("fl.f3", none);
        flush = 1'b0;
        clear_inputs();
        check("fl.ready_after", 64'(fu_ready), 64'hF);
        for (int i = 0; i < 3; i++) cyc($sformatf("fl.quiet%0d", i), none);

        // Asynchronous reset mid-cycle with an entry still buffered in FU2.
        set_fu(0, 6'h30); set_fu(1, 6'h31); set_fu(2, 6'h32);
        cyc("ar.enq", none);
        clear_inputs();
        cyc("ar.out", pair(2'b11, 6'h30, 6'h31));
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("ar.async");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("ar.ready", 64'(fu_ready), 64'hF);
        cyc("ar.discarded", none);
        set_fu(3, 6'h3A);
        cyc("ar.new_enq", none);
        clear_inputs();
        cyc("ar.new_out", pair(2'b01, 6'h3A, 6'h00));
        cyc("ar.idle", none);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Parametrised multi-port common data bus: collects results from NUM_FU functional units and broadcasts up to NUM_CDB of them per cycle.
- Each FU input feeds a small FIFO. A round-robin arbiter drains the FIFO heads onto registered CDB ports.
- Sits between the execute stage and the RS/ROB/map-table wakeup logic.
- Adds over the single-channel CDB: buffering, backpressure, fair arbitration, and branch-mispredict flush.

Parameters:
- NUM_FU, 4, number of functional-unit result inputs (>=2)
- NUM_CDB, 2, number of broadcast ports per cycle (1..NUM_FU)
- FIFO_DEPTH, 2, entries per FU FIFO (power of 2, >=2)
- TAG_W, 6, physical register tag width
- XLEN, 32, data and NPC width

Ports:
- clock  in  1  system clock, posedge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of all buffered and in-flight results
- fu_valid  in  NUM_FU  result valid per FU
- fu_tag  in  NUM_FU*TAG_W  destination tag
- fu_is_zeroreg  in  NUM_FU  destination is the zero register
- fu_value  in  NUM_FU*XLEN  ALU result
- fu_npc  in  NUM_FU*XLEN  next PC
- fu_take_branch  in  NUM_FU  branch taken
- fu_ready  out  NUM_FU  FIFO can accept this cycle
- cdb_valid  out  NUM_CDB  port carries a result
- cdb_tag  out  NUM_CDB*TAG_W  broadcast tag
- cdb_tag_valid  out  NUM_CDB  tag is meaningful (0 for zero-reg writes)
- cdb_value  out  NUM_CDB*XLEN  broadcast value
- cdb_npc  out  NUM_CDB*XLEN  broadcast NPC
- cdb_take_branch  out  NUM_CDB  broadcast branch outcome

Behaviour:
- Reset (async, active-high):
  - All FIFO counts and pointers become 0; rr_ptr becomes 0.
  - All cdb_* outputs become 0.
  - fu_ready is 0 while reset is high.
- fu_ready[i] = !reset && count[i] < FIFO_DEPTH. It depends on registered count only; there is no combinational path from the same-cycle dequeue.
- Enqueue: fu_valid[i] && fu_ready[i] at posedge writes the entry to the FIFO tail. fu_valid while not ready is a protocol violation; the bench asserts on it and the input is dropped.
- Arbitration is combinational on FIFO heads each cycle:
  - Scan FU indices rr_ptr, rr_ptr+1, ... mod NUM_FU.
  - Select the first min(NUM_CDB, #non-empty) non-empty FIFOs.
  - The k-th selected FIFO drives CDB port k.
  - At most one grant per FU per cycle.
- Output register: at posedge, port k loads its granted head (cdb_valid=1) and that FIFO pops. Ungranted ports load cdb_valid=0, and their other fields hold their previous values.
- rr_ptr next = (last granted index + 1) mod NUM_FU. rr_ptr is unchanged if nothing is granted.
- Latency: an entry accepted at edge t into an empty FIFO with a free port is broadcast at edge t+1 (visible in cycle t+1). There is no same-cycle bypass.
- cdb_tag_valid = !is_zeroreg of the broadcast entry. Zero-reg entries still consume a port, so NPC and branch outcome are still delivered.
- Simultaneous enqueue and pop on the same FIFO: both take effect; count is unchanged; FIFO order is preserved.
- Pointer wrap-around: pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- Flush at posedge (priority over enqueue and pop):
  - All counts and pointers become 0; rr_ptr becomes 0.
  - cdb_valid becomes all 0 in the next cycle.
  - fu_valid in that cycle is ignored.
  - fu_ready is 1 again one cycle later.
- Reset asserted mid-operation discards all state immediately, without waiting for a clock edge.
- Per-FU FIFO order is strict. Ordering across FUs follows the round-robin order only.

Test Plan:
- Reset, then FU0 valid with tag=5, value=0x1234, zeroreg=0 for one cycle -> next cycle cdb_valid=2'b01, cdb_tag[0]=5, cdb_tag_valid[0]=1, cdb_value[0]=0x1234; the following cycle cdb_valid=0.
- All 4 FUs valid in the same cycle with tags 1,2,3,4 -> cycle+1 ports carry tags 1,2; cycle+2 ports carry 3,4; rr_ptr returns to 0.
- FU2 held valid for 3 cycles while FU3 starves nothing (NUM_CDB=1 build) -> grant order FU2, FU3, FU2 alternates. fu_ready[2] drops to 0 when count=2.
- FU1 result with zeroreg=1, take_branch=1, npc=0x40 -> cdb_tag_valid=0, cdb_valid=1, cdb_take_branch=1, cdb_npc=0x40.
- Fill every FIFO (8 entries), then pulse flush -> cdb_valid=0 the next cycle and stays 0. All fu_ready are 1; no stale tag ever appears.
- Assert reset asynchronously mid-cycle with FIFOs non-empty -> cdb_valid and all outputs go to 0 before the next edge. After release, the first new result broadcasts with 1-cycle latency.
